// File: rtl/soml_pkg.sv
// soml_pkg: shared SOML decoder widths, accumulator sizing and hq_norm_acc state encoding
package soml_pkg;
  localparam int SOML_W = 16;
  localparam int SOML_N = 16;
  typedef enum logic [1:0] {ACC, DRAIN, HOLD} hq_norm_state_t;
  function automatic int acc_w(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction
endpackage

// File: rtl/cplx_sq_mag.sv
// cplx_sq_mag: registered squares of a signed complex sample's real and imaginary parts
module cplx_sq_mag #(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [W-1:0]     re,
  input  logic [W-1:0]     im,
  output logic             p_valid,
  output logic [2*W-1:0]   sq_r,
  output logic [2*W-1:0]   sq_i
);
  logic signed [2*W-1:0] pr, pi;
  assign pr = $signed(re) * $signed(re);
  assign pi = $signed(im) * $signed(im);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p_valid <= 1'b0;
      sq_r    <= '0;
      sq_i    <= '0;
    end else begin
      p_valid <= valid;
      if (valid) begin
        sq_r <= pr;
        sq_i <= pi;
      end
    end
endmodule

// File: rtl/hq_norm_acc.sv
// hq_norm_acc: accumulates |Hq|^2 over blocks of N samples and holds the block energy
// until the downstream stage accepts it
module hq_norm_acc
  import soml_pkg::*;
#(
  parameter int W     = SOML_W,
  parameter int N     = SOML_N,
  parameter int ACC_W = acc_w(W, N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             hq_valid,
  input  logic [W-1:0]     hq_r,
  input  logic [W-1:0]     hq_i,
  output logic             in_ready,
  output logic [ACC_W-1:0] norm,
  output logic             norm_valid,
  input  logic             norm_ready,
  output logic             busy
);
  localparam int CW = $clog2(N);
  hq_norm_state_t state;
  logic [CW-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic p_valid, accept;
  logic [2*W-1:0] sq_r, sq_i, sq_sum;
  assign in_ready   = state == ACC;
  assign norm_valid = state == HOLD;
  assign busy       = state != ACC;
  assign norm       = acc;
  // clr blocks the accept so stage 1 sees no valid and p_valid drops with it
  assign accept     = hq_valid && in_ready && !clr;
  assign sq_sum     = sq_r + sq_i;
  cplx_sq_mag #(.W(W)) u_sq (
    .clk(clk),
    .rst_n(rst_n),
    .valid(accept),
    .re(hq_r),
    .im(hq_i),
    .p_valid(p_valid),
    .sq_r(sq_r),
    .sq_i(sq_i)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ACC;
      cnt   <= '0;
      acc   <= '0;
    end else if (clr) begin
      state <= ACC;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      if (p_valid) acc <= acc + ACC_W'(sq_sum);
      case (state)
        ACC: if (accept) begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) state <= DRAIN;
        end
        DRAIN: state <= HOLD;
        HOLD: if (norm_ready) begin
          acc   <= '0;
          state <= ACC;
        end
        default: state <= ACC;
      endcase
    end
endmodule

// File: tb/tb_hq_norm_acc.sv
// tb_hq_norm_acc: directed checks of hq_norm_acc with N=4 and N=16 instances
module tb_hq_norm_acc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clr4 = 0, v4 = 0, nr4 = 1, ir4, nv4, busy4;
  logic [15:0] r4 = '0, i4 = '0;
  logic [33:0] n4;
  logic        clr16 = 0, v16 = 0, nr16 = 1, ir16, nv16, busy16;
  logic [15:0] r16 = '0, i16 = '0;
  logic [35:0] n16;

  int checks = 0;
  int failures = 0;

  hq_norm_acc #(.W(16), .N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .clr(clr4), .hq_valid(v4), .hq_r(r4), .hq_i(i4),
    .in_ready(ir4), .norm(n4), .norm_valid(nv4), .norm_ready(nr4), .busy(busy4)
  );
  hq_norm_acc #(.W(16), .N(16)) u16 (
    .clk(clk), .rst_n(rst_n), .clr(clr16), .hq_valid(v16), .hq_r(r16), .hq_i(i16),
    .in_ready(ir16), .norm(n16), .norm_valid(nv16), .norm_ready(nr16), .busy(busy16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", ir4, 1);
    chk("rst_norm_valid", nv4, 0);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", ir4, 1);
    chk("idle_norm_valid", nv4, 0);
    chk("idle_norm", n4, 0);
    chk("idle_busy", busy4, 0);
    chk("idle16_norm", n16, 0);

    // unit energy, N=4, norm_ready tied high
    v4 = 1; r4 = 16'd8192; i4 = 16'd0;
    repeat (4) step();
    v4 = 0;
    chk("unit_drain_valid", nv4, 0);
    chk("unit_drain_ready", ir4, 0);
    chk("unit_drain_busy", busy4, 1);
    step();
    chk("unit_hold_valid", nv4, 1);
    chk("unit_norm", n4, 64'd268435456);
    step();
    chk("unit_valid_1cyc", nv4, 0);
    chk("unit_ready_back", ir4, 1);
    chk("unit_acc_clear", n4, 0);

    // extreme block, N=16, with backpressure
    nr16 = 0; v16 = 1; r16 = 16'h8000; i16 = 16'h8000;
    repeat (16) step();
    r16 = 16'd3; i16 = 16'hFFFC;
    step();
    chk("ext_hold_valid", nv16, 1);
    chk("ext_norm", n16, 64'd34359738368);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_norm_stable", n16, 64'd34359738368);
      chk("bp_in_ready", ir16, 0);
      chk("bp_valid", nv16, 1);
    end
    nr16 = 1;
    step();
    chk("bp_release_valid", nv16, 0);
    chk("bp_release_ready", ir16, 1);
    chk("bp_acc_clear", n16, 0);
    repeat (16) step();
    v16 = 0;
    step();
    chk("mixed_valid", nv16, 1);
    chk("mixed_norm", n16, 64'd400);
    step();
    chk("mixed_done", nv16, 0);

    // clr mid-block with a valid sample in the same cycle
    v4 = 1; r4 = 16'd5; i4 = 16'd5;
    repeat (2) step();
    clr4 = 1;
    step();
    clr4 = 0; v4 = 0;
    chk("clr_norm_valid", nv4, 0);
    chk("clr_norm", n4, 0);
    chk("clr_in_ready", ir4, 1);
    v4 = 1; r4 = 16'd1; i4 = 16'd1;
    repeat (4) step();
    v4 = 0;
    step();
    chk("clr_next_valid", nv4, 1);
    chk("clr_next_norm", n4, 8);
    chk("clr_next_busy", busy4, 1);
    step();

    // async reset while holding a result
    nr4 = 0; v4 = 1; r4 = 16'd100; i4 = 16'd0;
    repeat (4) step();
    v4 = 0;
    step();
    chk("ar_hold_valid", nv4, 1);
    chk("ar_hold_norm", n4, 40000);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_norm_valid", nv4, 0);
    chk("ar_norm", n4, 0);
    chk("ar_in_ready", ir4, 1);
    chk("ar_busy", busy4, 0);
    #1 rst_n = 1'b1;
    nr4 = 1;
    step();
    chk("ar_post_valid", nv4, 0);
    chk("ar_post_ready", ir4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
